// File: rtl/peak_envelope_detector.sv
// Peak envelope follower: rectifies Q1.15 audio and tracks its peak with attack/hold/release ballistics.
// Two-stage CE-gated pipeline; define ENV_LOOKAHEAD_EN to delay o_data by LOOKAHEAD samples against o_env.
`timescale 1ns/1ps
module peak_envelope_detector #(
  parameter int W_TOTAL       = 16,
  parameter int ATTACK_SHIFT  = 2,
  parameter int RELEASE_SHIFT = 10,
  parameter int HOLD_SAMPLES  = 64,
  parameter int LOOKAHEAD     = 8
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_ce,
  input  logic [W_TOTAL-1:0] i_data,
  output logic [W_TOTAL-1:0] o_data,
  output logic [W_TOTAL-1:0] o_env,
  output logic               o_hold,
  output logic               o_ce
);

  localparam int FRAC = RELEASE_SHIFT;
  localparam int EW   = W_TOTAL - 1 + FRAC;
  localparam int DW   = EW + 1;
  localparam int HW   = (HOLD_SAMPLES > 0) ? $clog2(HOLD_SAMPLES + 1) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_SAMPLES);

  typedef enum logic [1:0] {
    ST_RELEASE,
    ST_ATTACK,
    ST_HOLD
  } state_t;

  logic [W_TOTAL-1:0] neg_data;
  logic [W_TOTAL-1:0] abs_data;
  logic [W_TOTAL-2:0] mag;

  logic               s1_ce;
  logic [W_TOTAL-2:0] s1_mag;
  logic [W_TOTAL-1:0] s1_data;

  // |most-negative| has its MSB set after negation; clamp it to full scale.
  always_comb begin
    neg_data = ~i_data + W_TOTAL'(1);
    abs_data = i_data[W_TOTAL-1] ? neg_data : i_data;
    mag      = abs_data[W_TOTAL-1] ? '1 : abs_data[W_TOTAL-2:0];
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      s1_ce   <= 1'b0;
      s1_mag  <= '0;
      s1_data <= '0;
    end else begin
      s1_ce <= i_ce;
      if (i_ce) begin
        s1_mag  <= mag;
        s1_data <= i_data;
      end
    end
  end

  state_t               state_q;
  state_t               state_nxt;
  logic [EW-1:0]        env_q;
  logic [EW-1:0]        env_nxt;
  logic [HW-1:0]        hold_q;
  logic [HW-1:0]        hold_nxt;
  logic [EW-1:0]        m_fix;
  logic signed [DW-1:0] diff;
  logic signed [DW-1:0] att_step;
  logic signed [DW-1:0] rel_step;

  // Attack step is at least one LSB so E always lands exactly on M; release floors so it never undershoots M.
  always_comb begin
    m_fix    = EW'(s1_mag) << FRAC;
    diff     = $signed({1'b0, m_fix}) - $signed({1'b0, env_q});
    att_step = diff >>> ATTACK_SHIFT;
    if (att_step == '0) begin
      att_step = DW'(1);
    end
    rel_step  = diff >>> RELEASE_SHIFT;
    state_nxt = state_q;
    env_nxt   = env_q;
    hold_nxt  = hold_q;
    if (s1_ce) begin
      if (m_fix > env_q) begin
        env_nxt   = env_q + EW'(att_step);
        hold_nxt  = HOLD_LOAD;
        state_nxt = ST_ATTACK;
      end else if (hold_q != '0) begin
        hold_nxt  = hold_q - HW'(1);
        state_nxt = ST_HOLD;
      end else begin
        env_nxt   = env_q + EW'(rel_step);
        state_nxt = ST_RELEASE;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= ST_RELEASE;
      env_q   <= '0;
      hold_q  <= '0;
      o_env   <= '0;
      o_ce    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      env_q   <= env_nxt;
      hold_q  <= hold_nxt;
      o_ce    <= s1_ce;
      if (s1_ce) begin
        o_env <= {1'b0, env_nxt[EW-1:FRAC]};
      end
    end
  end

  assign o_hold = (state_q == ST_HOLD);

`ifdef ENV_LOOKAHEAD_EN
  localparam int PW = (LOOKAHEAD > 1) ? $clog2(LOOKAHEAD) : 1;

  logic [W_TOTAL-1:0] la_buf [LOOKAHEAD];
  logic [PW-1:0]      la_ptr;

  // Read-before-write on one pointer: the slot read now was written LOOKAHEAD samples ago.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      la_ptr <= '0;
      o_data <= '0;
      for (int i = 0; i < LOOKAHEAD; i++) begin
        la_buf[i] <= '0;
      end
    end else if (s1_ce) begin
      o_data         <= la_buf[la_ptr];
      la_buf[la_ptr] <= s1_data;
      la_ptr         <= (la_ptr == PW'(LOOKAHEAD - 1)) ? '0 : la_ptr + PW'(1);
    end
  end
`else
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_data <= '0;
    end else if (s1_ce) begin
      o_data <= s1_data;
    end
  end
`endif

endmodule

// File: tb/tb_peak_envelope_detector.sv
// Directed bench for peak_envelope_detector: table of hand-computed attack/hold vectors plus ballistics sequences.
`timescale 1ns/1ps
module tb_peak_envelope_detector;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce = 1'b0;
  logic [15:0] din = 16'h0;
  logic [15:0] dout;
  logic [15:0] env;
  logic        hold;
  logic        oce;

  always #5 clk = ~clk;

  peak_envelope_detector dut (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .i_ce      (ce),
    .i_data    (din),
    .o_data    (dout),
    .o_env     (env),
    .o_hold    (hold),
    .o_ce      (oce)
  );

`ifdef ENV_LOOKAHEAD_EN
  localparam int LA = 8;
`else
  localparam int LA = 0;
`endif

  typedef struct packed {
    logic [15:0] d;
    logic [15:0] env;
    logic        hold;
  } out_t;

  typedef struct {
    logic [15:0] d;
    logic [15:0] env;
    logic        hold;
  } vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  int          out_k = 0;
  logic [15:0] hist[$];
  out_t        cap_q[$];

  always @(negedge clk) begin
    if (oce) cap_q.push_back({dout, env, hold});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; leaves at a negedge with the pipeline idle.
  task automatic do_reset();
    reset_n = 1'b0;
    ce      = 1'b1;
    din     = 16'h7FFF;
    repeat (3) @(negedge clk);
    check("rst_o_ce", oce, 0);
    check("rst_o_data", dout, 0);
    check("rst_o_env", env, 0);
    check("rst_o_hold", hold, 0);
    reset_n = 1'b1;
    ce      = 1'b0;
    din     = 16'h0;
    hist.delete();
    out_k = 0;
    @(negedge clk);
  endtask

  // One sample with idle clocks after it; checks 2-clk latency, pulse width and output hold.
  task automatic apply(input logic [15:0] d, input int gap, output out_t r);
    logic [15:0] exp_d;
    ce  = 1'b1;
    din = d;
    hist.push_back(d);
    @(negedge clk);
    ce  = 1'b0;
    din = ~d;
    check("o_ce_early", oce, 0);
    @(negedge clk);
    check("o_ce_lat2", oce, 1);
    r     = {dout, env, hold};
    exp_d = (out_k >= LA) ? hist[out_k-LA] : 16'h0;
    check("o_data", dout, exp_d);
    out_k++;
    @(negedge clk);
    check("o_ce_pulse", oce, 0);
    check("env_stable", env, r.env);
    check("data_stable", dout, r.d);
    repeat (gap - 1) @(negedge clk);
  endtask

  vec_t        tbl[9];
  logic [15:0] seq[20];
  out_t        cap_a[$];
  out_t        r;
  int          cnt;
  int          hit;
  logic [15:0] prev;
  logic [15:0] max_env;

  initial begin
    tbl[0] = '{d: 16'h4000, env: 16'h1000, hold: 1'b0};
    tbl[1] = '{d: 16'h4000, env: 16'h1C00, hold: 1'b0};
    tbl[2] = '{d: 16'h4000, env: 16'h2500, hold: 1'b0};
    tbl[3] = '{d: 16'hC000, env: 16'h2BC0, hold: 1'b0};
    tbl[4] = '{d: 16'h8000, env: 16'h40CF, hold: 1'b0};
    tbl[5] = '{d: 16'h0000, env: 16'h40CF, hold: 1'b1};
    tbl[6] = '{d: 16'h7FFF, env: 16'h509B, hold: 1'b0};
    tbl[7] = '{d: 16'h0001, env: 16'h509B, hold: 1'b1};
    tbl[8] = '{d: 16'hFFFF, env: 16'h509B, hold: 1'b1};
    for (int i = 0; i < 20; i++) seq[i] = tbl[i % 9].d ^ 16'(i * 16'h0321);

    @(negedge clk);
    do_reset();
    for (int i = 0; i < 9; i++) begin
      apply(tbl[i].d, 2, r);
      check($sformatf("vec%0d_env", i), r.env, tbl[i].env);
      check($sformatf("vec%0d_hold", i), r.hold, tbl[i].hold);
    end

    // Full-scale negative saturates to 7FFF and the envelope converges there without overshoot.
    cnt = 0;
    max_env = 16'h0;
    do begin
      apply(16'h8000, 1, r);
      if (r.env > max_env) max_env = r.env;
      cnt++;
    end while (r.env != 16'h7FFF && cnt < 200);
    check("sat_conv", r.env, 16'h7FFF);
    check("sat_max", max_env, 16'h7FFF);

    do_reset();
    apply(16'hC000, 1, r);
    check("neg_rect_env", r.env, 16'h1000);

    // Attack to 4000, then hold for exactly HOLD_SAMPLES, then release.
    do_reset();
    cnt = 0;
    max_env = 16'h0;
    do begin
      apply(16'h4000, 1, r);
      if (r.env > max_env) max_env = r.env;
      cnt++;
    end while (r.env != 16'h4000 && cnt < 200);
    check("att_conv", r.env, 16'h4000);
    check("att_max", max_env, 16'h4000);
    check("att_hold", r.hold, 0);
    cnt = 0;
    apply(16'h0000, 1, r);
    while (r.hold && cnt < 100) begin
      check("hold_env", r.env, 16'h4000);
      cnt++;
      apply(16'h0000, 1, r);
    end
    check("hold_len", cnt, 64);
    check("rel_first", r.env, 16'h3FF0);
    prev = r.env;
    for (int i = 0; i < 4; i++) begin
      apply(16'h0000, 1, r);
      check("rel_dec", r.env < prev, 1);
      prev = r.env;
    end

    // Re-attack from release, then again from inside hold; hold counter reloads.
    apply(16'h6000, 1, r);
    check("reatt1_hold", r.hold, 0);
    check("reatt1_rise", r.env > prev, 1);
    prev = r.env;
    for (int i = 0; i < 10; i++) begin
      apply(16'h0000, 1, r);
      check("mid_hold", r.hold, 1);
    end
    apply(16'h6000, 1, r);
    check("reatt2_hold", r.hold, 0);
    check("reatt2_rise", r.env > prev, 1);
    cnt = 0;
    apply(16'h0000, 1, r);
    while (r.hold && cnt < 100) begin
      cnt++;
      apply(16'h0000, 1, r);
    end
    check("rehold_len", cnt, 64);

    // Impulse: envelope jumps at the impulse sample, audio appears LA samples later.
    do_reset();
    hit = -1;
    for (int i = 0; i < 16; i++) begin
      apply((i == 3) ? 16'h7FFF : 16'h0000, 1, r);
      if (i == 3) check("imp_env", r.env, 16'h1FFF);
      if (r.d == 16'h7FFF && hit < 0) hit = i;
    end
    check("imp_data_pos", hit, 3 + LA);

    // Reset while a sample is in flight drops it.
    cap_q.delete();
    ce  = 1'b1;
    din = 16'h1234;
    @(negedge clk);
    ce      = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_no_oce", cap_q.size(), 0);

    // Same samples back-to-back and 48 clk apart must give identical outputs.
    do_reset();
    cap_q.delete();
    for (int i = 0; i < 20; i++) begin
      ce  = 1'b1;
      din = seq[i];
      @(negedge clk);
    end
    ce = 1'b0;
    repeat (4) @(negedge clk);
    cap_a = cap_q;
    do_reset();
    cap_q.delete();
    for (int i = 0; i < 20; i++) apply(seq[i], 48, r);
    check("tput_cnt_a", cap_a.size(), 20);
    check("tput_cnt_b", cap_q.size(), 20);
    if (cap_a.size() == 20 && cap_q.size() == 20) begin
      for (int i = 0; i < 20; i++) begin
        check($sformatf("tput%0d_env", i), cap_a[i].env, cap_q[i].env);
        check($sformatf("tput%0d_data", i), cap_a[i].d, cap_q[i].d);
        check($sformatf("tput%0d_hold", i), cap_a[i].hold, cap_q[i].hold);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
